ahmes_alu_ctrl: RTL and testbench
=================================

# ahmes_alu_ctrl

Sequential execution controller that drives the Ahmes ALU as its initiator. It owns the accumulator (AC) and the N/Z/C/V/B flag register, and accepts one operation at a time from the instruction sequencer over a valid/ready handshake. For each operation it presents AC, the memory operand and the carry flag to the ALU, then writes back the result and a per-operation subset of flags. It sits between the control FSM and the combinational ALU.

## Interface
- No parameters; datapath fixed at 8 bits, op code fixed at 4 bits.
- clk  in  1  system clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  sequencer presents an operation.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_op  in  4  operation code (ALU codes plus local LDA/NOP).
- req_data  in  8  memory operand (operB / load value).
- done  out  1  one-cycle pulse: write-back completed.
- err  out  1  one-cycle pulse: illegal op rejected.
- ac  out  8  accumulator, registered.
- flag_n, flag_z, flag_c, flag_v, flag_b  out  1 each  registered flags.
- operacao  out  4  to ALU.
- operA  out  8  to ALU, equals ac.
- operB  out  8  to ALU, registered operand.
- Cin  out  1  to ALU, equals flag_c.
- result  in  8  from ALU.
- N, Z, C, B, V  in  1 each  from ALU.
- cond  in  4  branch condition code (only with AHMES_BRANCH_EVAL_EN).
- cond_true  out  1  condition satisfied by current flags (only with AHMES_BRANCH_EVAL_EN).

## Operation
- Op codes: 0000 LDA, 0001 ADIC, 0010 SUB, 0011 OU, 0100 E, 0101 NAO, 0110 DLE (rotate left through Cin), 0111 DLD (rotate right through Cin), 1000 DAE, 1001 DAD, 1111 NOP; 1010-1110 illegal.
- FSM: IDLE -> EXEC -> DONE -> IDLE; illegal op: IDLE -> ERR -> IDLE.
- IDLE: req_ready=1; on req_valid, latch req_op into op register and req_data into operB register.
- EXEC: operacao driven from op register; ALU settles combinationally; at the edge ending EXEC, write back.
- Write-back: LDA: ac<=operB, N/Z from operB (N=bit7, Z=operB==0). ADIC: ac<=result, update N,Z,C,V. SUB: ac<=result, update N,Z,V,B. OU/E/NAO: ac<=result, update N,Z. DLE/DLD/DAE/DAD: ac<=result, update N,Z,C. NOP: no change. Flags not listed hold.
- DONE: done=1 for one cycle. ERR: err=1 for one cycle, ac and flags unchanged.
- operacao in IDLE/DONE/ERR is 4'b0000; ALU output ignored outside EXEC.
- req_op/req_data changes after acceptance have no effect.

## Timing
- Reset (reset_n=0 at edge): state IDLE, ac=0, all flags 0, operB=0, done=0, err=0; req_ready=1 from the first cycle after reset. Reset in any state aborts the operation with no write-back.
- Accept at edge k; EXEC during cycle k+1; ac/flags valid and done=1 in cycle k+2; req_ready=1 again in cycle k+3.
- Throughput: one operation per 3 cycles; illegal op: err in cycle k+1, req_ready in k+2.
- req_ready is a registered function of state; it does not depend on req_valid.
- cond_true is combinational from registered flags and cond; it reflects write-back from cycle k+2.

## Configuration
- AHMES_BRANCH_EVAL_EN defined: cond/cond_true present. cond: 0 JN (N), 1 JP (!N), 2 JV (V), 3 JNV (!V), 4 JZ (Z), 5 JNZ (!Z), 6 JC (C), 7 JNC (!C), 8 JB (B), 9 JNB (!B), 10-15 -> 0.
- Not defined: cond and cond_true ports absent; the sequencer evaluates branches itself. All other behaviour identical.

## Test plan
- LDA 10 then ADIC 20 -> ac=30, N=0 Z=0 C=0 V=0; done in cycle k+2 for each op.
- LDA 255 then ADIC 1 -> ac=0, Z=1, C=1, N=0, V=0; then LDA 0, SUB 1 -> ac=255, N=1, B=1, Z=0, C still 1.
- Set C=1 (LDA 255, ADIC 1), LDA 129, DLE -> ac=3, C=1; LDA 129, DAD -> ac=64, C=1, N=0.
- Illegal op 1011 with ac=30 -> err pulse in k+1, no done, ac=30 and flags unchanged, req_ready back in k+2.
- Assert reset_n=0 during EXEC of ADIC -> ac=0, flags 0, no done, req_ready=1 after reset release.
- With AHMES_BRANCH_EVAL_EN, after SUB giving 255: cond=0 -> cond_true=1, cond=4 -> 0, cond=8 -> 1, cond=12 -> 0.

Source files
------------

// File: rtl/ahmes_alu_ctrl.sv
// Execution controller for the Ahmes ALU: owns AC and the N/Z/C/V/B flags.
// Define AHMES_BRANCH_EVAL_EN to add the cond/cond_true branch evaluator.
module ahmes_alu_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       err,
  output logic [7:0] ac,
  output logic       flag_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_b,
  output logic [3:0] operacao,
  output logic [7:0] operA,
  output logic [7:0] operB,
  output logic       Cin,
  input  logic [7:0] result,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       B,
  input  logic       V
`ifdef AHMES_BRANCH_EVAL_EN
  ,
  input  logic [3:0] cond,
  output logic       cond_true
`endif
);

  localparam logic [3:0] OpLda  = 4'b0000;
  localparam logic [3:0] OpAdic = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpOu   = 4'b0011;
  localparam logic [3:0] OpE    = 4'b0100;
  localparam logic [3:0] OpNao  = 4'b0101;
  localparam logic [3:0] OpDle  = 4'b0110;
  localparam logic [3:0] OpDld  = 4'b0111;
  localparam logic [3:0] OpDae  = 4'b1000;
  localparam logic [3:0] OpDad  = 4'b1001;
  localparam logic [3:0] OpNop  = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone,
    StErr
  } state_e;

  state_e     state_q;
  logic [3:0] op_q;
  logic [7:0] operb_q;
  logic       req_legal;
  logic       accept;

  // Write-back candidates, applied only at the edge that ends EXEC.
  logic [7:0] ac_wb;
  logic       n_wb;
  logic       z_wb;
  logic       c_wb;
  logic       v_wb;
  logic       b_wb;

  assign req_legal = (req_op <= OpDad) || (req_op == OpNop);
  assign accept    = req_ready && req_valid;

  assign operacao = (state_q == StExec) ? op_q : 4'b0000;
  assign operA    = ac;
  assign operB    = operb_q;
  assign Cin      = flag_c;

  always_comb begin
    ac_wb = ac;
    n_wb  = flag_n;
    z_wb  = flag_z;
    c_wb  = flag_c;
    v_wb  = flag_v;
    b_wb  = flag_b;
    unique case (op_q)
      OpLda: begin
        ac_wb = operb_q;
        n_wb  = operb_q[7];
        z_wb  = (operb_q == 8'h00);
      end
      OpAdic: begin
        ac_wb = result;
        n_wb  = N;
        z_wb  = Z;
        c_wb  = C;
        v_wb  = V;
      end
      OpSub: begin
        ac_wb = result;
        n_wb  = N;
        z_wb  = Z;
        v_wb  = V;
        b_wb  = B;
      end
      OpOu, OpE, OpNao: begin
        ac_wb = result;
        n_wb  = N;
        z_wb  = Z;
      end
      OpDle, OpDld, OpDae, OpDad: begin
        ac_wb = result;
        n_wb  = N;
        z_wb  = Z;
        c_wb  = C;
      end
      default: ;  // NOP; illegal codes never reach EXEC
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= OpNop;
      operb_q   <= 8'h00;
      ac        <= 8'h00;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_b    <= 1'b0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_legal) begin
              state_q <= StExec;
              op_q    <= req_op;
              operb_q <= req_data;
            end else begin
              state_q <= StErr;
              err     <= 1'b1;
            end
          end
        end
        StExec: begin
          state_q <= StDone;
          done    <= 1'b1;
          ac      <= ac_wb;
          flag_n  <= n_wb;
          flag_z  <= z_wb;
          flag_c  <= c_wb;
          flag_v  <= v_wb;
          flag_b  <= b_wb;
        end
        StDone: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
        StErr: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef AHMES_BRANCH_EVAL_EN
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = flag_n;
      4'd1:    cond_true = !flag_n;
      4'd2:    cond_true = flag_v;
      4'd3:    cond_true = !flag_v;
      4'd4:    cond_true = flag_z;
      4'd5:    cond_true = !flag_z;
      4'd6:    cond_true = flag_c;
      4'd7:    cond_true = !flag_c;
      4'd8:    cond_true = flag_b;
      4'd9:    cond_true = !flag_b;
      default: cond_true = 1'b0;
    endcase
  end
`endif

endmodule

// File: tb/tb_ahmes_alu_ctrl.sv
// Directed bench for ahmes_alu_ctrl with a behavioural Ahmes ALU attached.
module tb_ahmes_alu_ctrl;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_data;
  logic       done;
  logic       err;
  logic [7:0] ac;
  logic       flag_n, flag_z, flag_c, flag_v, flag_b;
  logic [3:0] operacao;
  logic [7:0] opa;
  logic [7:0] opb;
  logic       cin;
  logic [7:0] alu_res;
  logic       alu_n, alu_z, alu_c, alu_b, alu_v;
`ifdef AHMES_BRANCH_EVAL_EN
  logic [3:0] cond;
  logic       cond_true;
`endif

  int n_total = 0;
  int n_bad   = 0;

  ahmes_alu_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .done      (done),
    .err       (err),
    .ac        (ac),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_b    (flag_b),
    .operacao  (operacao),
    .operA     (opa),
    .operB     (opb),
    .Cin       (cin),
    .result    (alu_res),
    .N         (alu_n),
    .Z         (alu_z),
    .C         (alu_c),
    .B         (alu_b),
    .V         (alu_v)
`ifdef AHMES_BRANCH_EVAL_EN
    ,
    .cond      (cond),
    .cond_true (cond_true)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; DAD is a logical right shift with the dropped bit into C.
  always_comb begin
    logic [8:0] sum;
    sum     = {1'b0, opa} + {1'b0, opb} + {8'h00, cin};
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_b   = 1'b0;
    case (operacao)
      4'h1: begin
        alu_res = sum[7:0];
        alu_c   = sum[8];
        alu_v   = (opa[7] == opb[7]) && (sum[7] != opa[7]);
      end
      4'h2: begin
        alu_res = opa - opb;
        alu_b   = opa < opb;
        alu_v   = (opa[7] != opb[7]) && (alu_res[7] != opa[7]);
      end
      4'h3: alu_res = opa | opb;
      4'h4: alu_res = opa & opb;
      4'h5: alu_res = ~opa;
      4'h6: begin alu_res = {opa[6:0], cin};  alu_c = opa[7]; end
      4'h7: begin alu_res = {cin, opa[7:1]};  alu_c = opa[0]; end
      4'h8: begin alu_res = {opa[6:0], 1'b0}; alu_c = opa[7]; end
      4'h9: begin alu_res = {1'b0, opa[7:1]}; alu_c = opa[0]; end
      default: ;
    endcase
    alu_n = alu_res[7];
    alu_z = (alu_res == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected flags packed as {n, z, c, v, b}.
  task automatic check_state(input string tag, input logic [7:0] exp_ac, input logic [4:0] exp_f);
    check({tag, "_ac"}, {24'h0, ac}, {24'h0, exp_ac});
    check({tag, "_flags"}, {27'h0, flag_n, flag_z, flag_c, flag_v, flag_b}, {27'h0, exp_f});
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] d, input bit illegal);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_issue", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = d;
    @(posedge clk);
    #1;
    // Scramble the request bus: it must not affect the accepted operation.
    req_valid = 1'b0;
    req_op    = 4'b1100;
    req_data  = ~d;
    if (illegal) begin
      check("err_k1", {31'h0, err}, 32'h1);
      check("nodone_k1", {31'h0, done}, 32'h0);
      check("busy_k1", {31'h0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
      check("err_k2", {31'h0, err}, 32'h0);
      check("nodone_k2", {31'h0, done}, 32'h0);
      check("ready_k2", {31'h0, req_ready}, 32'h1);
    end else begin
      check("done_k1", {31'h0, done}, 32'h0);
      check("busy_k1", {31'h0, req_ready}, 32'h0);
      check("operacao_exec", {28'h0, operacao}, {28'h0, (op == 4'hF) ? 4'hF : op});
      @(posedge clk);
      #1;
      check("done_k2", {31'h0, done}, 32'h1);
      check("busy_k2", {31'h0, req_ready}, 32'h0);
      check("operacao_done", {28'h0, operacao}, 32'h0);
      @(posedge clk);
      #1;
      check("done_k3", {31'h0, done}, 32'h0);
      check("ready_k3", {31'h0, req_ready}, 32'h1);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_data  = 8'h00;
`ifdef AHMES_BRANCH_EVAL_EN
    cond      = 4'h0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 5'b00000);
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    check("reset_done", {31'h0, done}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    check("reset_operb", {24'h0, opb}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(4'h0, 8'd10, 1'b0);
    check_state("lda10", 8'd10, 5'b00000);
    issue(4'h1, 8'd20, 1'b0);
    check_state("adic20", 8'd30, 5'b00000);

    issue(4'hB, 8'h77, 1'b1);
    check_state("illegal", 8'd30, 5'b00000);

    issue(4'h0, 8'd255, 1'b0);
    check_state("lda255", 8'd255, 5'b10000);
    issue(4'h1, 8'd1, 1'b0);
    check_state("adic1", 8'd0, 5'b01100);

    issue(4'h0, 8'd0, 1'b0);
    check_state("lda0", 8'd0, 5'b01100);
    issue(4'h2, 8'd1, 1'b0);
    check_state("sub1", 8'd255, 5'b10101);
`ifdef AHMES_BRANCH_EVAL_EN
    cond = 4'd0;  #1; check("cond_jn", {31'h0, cond_true}, 32'h1);
    cond = 4'd4;  #1; check("cond_jz", {31'h0, cond_true}, 32'h0);
    cond = 4'd8;  #1; check("cond_jb", {31'h0, cond_true}, 32'h1);
    cond = 4'd12; #1; check("cond_rsv", {31'h0, cond_true}, 32'h0);
`endif

    issue(4'h0, 8'd129, 1'b0);
    check_state("lda129a", 8'd129, 5'b10101);
    issue(4'h6, 8'h00, 1'b0);
    check_state("dle", 8'd3, 5'b00101);
    issue(4'h0, 8'd129, 1'b0);
    issue(4'h9, 8'h00, 1'b0);
    check_state("dad", 8'd64, 5'b00101);
    issue(4'hF, 8'h12, 1'b0);
    check_state("nop", 8'd64, 5'b00101);

    issue(4'h3, 8'h0F, 1'b0);
    check_state("ou", 8'h4F, 5'b00101);
    issue(4'h4, 8'hF0, 1'b0);
    check_state("e", 8'h40, 5'b00101);
    issue(4'h5, 8'h00, 1'b0);
    check_state("nao", 8'hBF, 5'b10101);
    issue(4'h7, 8'h00, 1'b0);
    check_state("dld", 8'hDF, 5'b10101);
    issue(4'h8, 8'h00, 1'b0);
    check_state("dae", 8'hBE, 5'b10101);

    // Reset while ADIC is in EXEC: no write-back, no done.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'h1;
    req_data  = 8'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_exec_op", {28'h0, operacao}, 32'h1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_state("rst_exec", 8'h00, 5'b00000);
    check("rst_exec_done", {31'h0, done}, 32'h0);
    check("rst_exec_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_done", {31'h0, done}, 32'h0);
    check("post_rst_ready", {31'h0, req_ready}, 32'h1);
    check_state("post_rst", 8'h00, 5'b00000);

    issue(4'h0, 8'h80, 1'b0);
    check_state("lda80", 8'h80, 5'b10000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
